// File: rtl/ram_arb_pkg.sv
// Shared types and sizing helpers for the SDRAM request-port round-robin arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int TIMER_WIDTH = 16;

    // Width of a requester index; never below 1 so a 1-bit GRANT still exists.
    function automatic int grant_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the slot after the last
// winner sits at bit 0, priority-encode, then un-rotate back to a requester index.
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter  int COUNT = 4,
    localparam int GW    = grant_width(COUNT)
) (
    input  logic [COUNT-1:0] i_req,
    input  logic [GW-1:0]    i_last,
    output logic             o_valid,
    output logic [GW-1:0]    o_winner
);

    logic [GW-1:0]    w_start;
    logic [GW-1:0]    w_offset;
    logic [COUNT-1:0] w_req_rot;

    assign w_start = (i_last == GW'(COUNT - 1)) ? '0 : i_last + 1'b1;
    assign o_valid = |i_req;

    always_comb begin
        w_req_rot = '0;
        for (int k = 0; k < COUNT; k++) begin
            int idx;
            idx = k + int'(w_start);
            if (idx >= COUNT) begin
                idx = idx - COUNT;
            end
            w_req_rot[k] = i_req[idx];
        end
    end

    // Descending scan so the lowest set rotated bit is the one left standing.
    always_comb begin
        w_offset = '0;
        for (int k = COUNT - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_offset = GW'(k);
            end
        end
    end

    always_comb begin
        int sum;
        sum = int'(w_start) + int'(w_offset);
        if (sum >= COUNT) begin
            sum = sum - COUNT;
        end
        o_winner = GW'(sum);
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter that funnels COUNT requesters onto one SDRAM controller port,
// one transaction at a time, with a watchdog that force-completes stalled accesses.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int COUNT      = 4,
    parameter  int ADDR_WIDTH = 23,
    parameter  int DATA_WIDTH = 32,
    parameter  int BE_WIDTH   = 4,
    parameter  int TIMEOUT    = 255,
    localparam int GW         = grant_width(COUNT)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [COUNT-1:0]              i_req,
    input  logic [COUNT-1:0]              i_we,
    input  logic [COUNT*ADDR_WIDTH-1:0]   i_addr,
    input  logic [COUNT*DATA_WIDTH-1:0]   i_din,
    input  logic [COUNT*BE_WIDTH-1:0]     i_be,
    output logic [COUNT-1:0]              o_ack,
    output logic [DATA_WIDTH-1:0]         o_dout,
    output logic                          o_err,
    output logic [GW-1:0]                 o_grant,
    output logic                          o_busy,
    output logic                          o_p_req,
    output logic                          o_p_we,
    output logic [ADDR_WIDTH-1:0]         o_p_addr,
    output logic [DATA_WIDTH-1:0]         o_p_din,
    output logic [BE_WIDTH-1:0]           o_p_be,
    input  logic                          i_p_ack,
    input  logic [DATA_WIDTH-1:0]         i_p_dout
);

    state_t                 r_state,  w_state_next;
    logic [GW-1:0]          r_last,   w_last_next;
    logic [GW-1:0]          r_grant,  w_grant_next;
    logic [TIMER_WIDTH-1:0] r_timer,  w_timer_next;
    logic [COUNT-1:0]       r_ack,    w_ack_next;
    logic                   r_err,    w_err_next;
    logic [DATA_WIDTH-1:0]  r_dout,   w_dout_next;
    logic                   r_p_req,  w_p_req_next;
    logic                   r_p_we,   w_p_we_next;
    logic [ADDR_WIDTH-1:0]  r_p_addr, w_p_addr_next;
    logic [DATA_WIDTH-1:0]  r_p_din,  w_p_din_next;
    logic [BE_WIDTH-1:0]    r_p_be,   w_p_be_next;

    logic [ADDR_WIDTH-1:0]  w_addr_arr [COUNT];
    logic [DATA_WIDTH-1:0]  w_din_arr  [COUNT];
    logic [BE_WIDTH-1:0]    w_be_arr   [COUNT];

    logic                   w_pick_valid;
    logic [GW-1:0]          w_pick_winner;
    logic                   w_timeout;
    logic [COUNT-1:0]       w_grant_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < COUNT; gi++) begin : g_slice
            assign w_addr_arr[gi] = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_din_arr[gi]  = i_din[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_be_arr[gi]   = i_be[gi*BE_WIDTH +: BE_WIDTH];
        end
    endgenerate

    rr_pick #(
        .COUNT (COUNT)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_winner)
    );

    // The cycle that would bring the count to TIMEOUT is the last one spent in ISSUE.
    assign w_timeout      = (r_timer == TIMER_WIDTH'(TIMEOUT - 1));
    assign w_grant_onehot = COUNT'(1) << r_grant;

    always_comb begin
        w_state_next  = r_state;
        w_last_next   = r_last;
        w_grant_next  = r_grant;
        w_timer_next  = r_timer;
        w_ack_next    = '0;
        w_err_next    = r_err;
        w_dout_next   = r_dout;
        w_p_req_next  = r_p_req;
        w_p_we_next   = r_p_we;
        w_p_addr_next = r_p_addr;
        w_p_din_next  = r_p_din;
        w_p_be_next   = r_p_be;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_p_req_next  = 1'b1;
                    w_p_we_next   = i_we[w_pick_winner];
                    w_p_addr_next = w_addr_arr[w_pick_winner];
                    w_p_din_next  = w_din_arr[w_pick_winner];
                    w_p_be_next   = w_be_arr[w_pick_winner];
                    w_grant_next  = w_pick_winner;
                    w_last_next   = w_pick_winner;
                    w_timer_next  = '0;
                    w_state_next  = ISSUE;
                end
            end
            ISSUE: begin
                w_timer_next = r_timer + 1'b1;
                // A controller ack in the timeout cycle still counts as a clean completion.
                if (i_p_ack) begin
                    w_dout_next  = i_p_dout;
                    w_err_next   = 1'b0;
                    w_p_req_next = 1'b0;
                    w_ack_next   = w_grant_onehot;
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_dout_next  = '0;
                    w_err_next   = 1'b1;
                    w_p_req_next = 1'b0;
                    w_ack_next   = w_grant_onehot;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_err_next   = 1'b0;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_last   <= GW'(COUNT - 1);
            r_grant  <= '0;
            r_timer  <= '0;
            r_ack    <= '0;
            r_err    <= 1'b0;
            r_dout   <= '0;
            r_p_req  <= 1'b0;
            r_p_we   <= 1'b0;
            r_p_addr <= '0;
            r_p_din  <= '0;
            r_p_be   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_last   <= w_last_next;
            r_grant  <= w_grant_next;
            r_timer  <= w_timer_next;
            r_ack    <= w_ack_next;
            r_err    <= w_err_next;
            r_dout   <= w_dout_next;
            r_p_req  <= w_p_req_next;
            r_p_we   <= w_p_we_next;
            r_p_addr <= w_p_addr_next;
            r_p_din  <= w_p_din_next;
            r_p_be   <= w_p_be_next;
        end
    end

    assign o_ack    = r_ack;
    assign o_dout   = r_dout;
    assign o_err    = r_err;
    assign o_grant  = r_grant;
    assign o_busy   = (r_state != IDLE);
    assign o_p_req  = r_p_req;
    assign o_p_we   = r_p_we;
    assign o_p_addr = r_p_addr;
    assign o_p_din  = r_p_din;
    assign o_p_be   = r_p_be;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Randomized bench for ram_rr_arbiter: a transaction-level round-robin model and a
// scripted controller predict grant, latched fields, completion cycle, data and error.
module tb_ram_rr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int TO   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      i_req;
    logic [NREQ-1:0]      i_we;
    logic [NREQ*AW-1:0]   i_addr;
    logic [NREQ*DW-1:0]   i_din;
    logic [NREQ*BW-1:0]   i_be;
    logic [NREQ-1:0]      o_ack;
    logic [DW-1:0]        o_dout;
    logic                 o_err;
    logic [1:0]           o_grant;
    logic                 o_busy;
    logic                 o_p_req;
    logic                 o_p_we;
    logic [AW-1:0]        o_p_addr;
    logic [DW-1:0]        o_p_din;
    logic [BW-1:0]        o_p_be;
    logic                 i_p_ack;
    logic [DW-1:0]        i_p_dout;

    logic [AW-1:0] a_addr [NREQ];
    logic          a_we   [NREQ];
    logic [DW-1:0] a_din  [NREQ];
    logic [BW-1:0] a_be   [NREQ];

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;
    int model_last;

    ram_rr_arbiter #(
        .COUNT      (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_req    (i_req),
        .i_we     (i_we),
        .i_addr   (i_addr),
        .i_din    (i_din),
        .i_be     (i_be),
        .o_ack    (o_ack),
        .o_dout   (o_dout),
        .o_err    (o_err),
        .o_grant  (o_grant),
        .o_busy   (o_busy),
        .o_p_req  (o_p_req),
        .o_p_we   (o_p_we),
        .o_p_addr (o_p_addr),
        .o_p_din  (o_p_din),
        .o_p_be   (o_p_be),
        .i_p_ack  (i_p_ack),
        .i_p_dout (i_p_dout)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First set request scanning upward from the slot after the previous winner.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        for (int s = 1; s <= NREQ; s++) begin
            int idx;
            idx = (last + s) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic pack_fields();
        for (int i = 0; i < NREQ; i++) begin
            i_we[i]            = a_we[i];
            i_addr[i*AW +: AW] = a_addr[i];
            i_din[i*DW +: DW]  = a_din[i];
            i_be[i*BW +: BW]   = a_be[i];
        end
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = AW'($urandom);
            a_we[i]   = 1'($urandom_range(0, 1));
            a_din[i]  = $urandom;
            a_be[i]   = BW'($urandom);
        end
        pack_fields();
    endtask

    // Starts in an IDLE cycle, runs one transaction, and returns in the following IDLE cycle.
    // k is the ISSUE cycle in which the controller acks; k >= TO means it never does.
    task automatic run_txn(input logic [NREQ-1:0] req_pat, input int k,
                           input logic [DW-1:0] data, output int winner);
        int            w;
        int            c;
        int            exit_c;
        bit            done;
        logic          exp_err;
        logic [DW-1:0] exp_dout;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [DW-1:0] e_din;
        logic [BW-1:0] e_be;

        w      = model_pick(req_pat, model_last);
        e_addr = a_addr[w];
        e_we   = a_we[w];
        e_din  = a_din[w];
        e_be   = a_be[w];
        i_req    = req_pat;
        i_p_ack  = 1'($urandom_range(0, 1));
        i_p_dout = $urandom;
        @(posedge clk); #1;
        check_value("latch_p_req", o_p_req, 1);
        check_value("latch_grant", o_grant, w);
        check_value("latch_p_we", o_p_we, e_we);
        check_value("latch_p_addr", o_p_addr, e_addr);
        check_value("latch_p_din", o_p_din, e_din);
        check_value("latch_p_be", o_p_be, e_be);
        check_value("latch_busy", o_busy, 1);
        check_value("latch_no_ack", o_ack, 0);
        model_last = w;

        exit_c = (k < TO) ? k : TO - 1;
        c      = 0;
        done   = 0;
        while (!done && c < 40) begin
            i_p_ack  = (c == k);
            i_p_dout = (c == k) ? data : $urandom;
            randomize_fields();
            i_req = NREQ'($urandom);
            @(posedge clk); #1;
            if (o_ack != 0) begin
                done = 1;
            end else begin
                check_value("hold_p_req", o_p_req, 1);
                check_value("hold_p_addr", o_p_addr, e_addr);
                c++;
            end
        end
        check_value("resp_seen", done, 1);
        check_value("exit_cycle", c, exit_c);

        exp_err  = (k >= TO);
        exp_dout = exp_err ? '0 : data;
        check_value("resp_ack", o_ack, 64'(1) << w);
        check_value("resp_err", o_err, exp_err);
        check_value("resp_dout", o_dout, exp_dout);
        check_value("resp_p_req", o_p_req, 0);
        check_value("resp_grant", o_grant, w);
        $display("txn %0d req=%b grant=%0d we=%0b addr=%h ack_cyc=%0d err=%0b dout=%h",
                 n_txn, req_pat, o_grant, e_we, e_addr, c, o_err, o_dout);
        n_txn++;

        i_req    = '0;
        i_p_ack  = 1'($urandom_range(0, 1));
        i_p_dout = $urandom;
        @(posedge clk); #1;
        check_value("idle_ack", o_ack, 0);
        check_value("idle_err", o_err, 0);
        check_value("idle_busy", o_busy, 0);
        check_value("idle_p_req", o_p_req, 0);
        i_p_ack = 1'b0;
        winner  = w;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_ack"}, o_ack, 0);
        check_value({tag, "_err"}, o_err, 0);
        check_value({tag, "_dout"}, o_dout, 0);
        check_value({tag, "_grant"}, o_grant, 0);
        check_value({tag, "_busy"}, o_busy, 0);
        check_value({tag, "_p_req"}, o_p_req, 0);
        check_value({tag, "_p_fields"}, {o_p_we, o_p_addr, o_p_be}, 0);
        check_value({tag, "_p_din"}, o_p_din, 0);
    endtask

    initial begin
        int w;
        int rr_exp [5];
        rr_exp = '{0, 1, 2, 3, 0};

        rst      = 1'b1;
        i_req    = '0;
        i_p_ack  = 1'b0;
        i_p_dout = '0;
        randomize_fields();
        model_last = NREQ - 1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // All requesters pending: grants rotate starting at requester 0.
        for (int t = 0; t < 5; t++) begin
            randomize_fields();
            run_txn(4'b1111, 1, $urandom, w);
            check_value("rr_order", w, rr_exp[t]);
        end

        randomize_fields();
        a_addr[0] = 23'h000123;
        a_we[0]   = 1'b0;
        pack_fields();
        run_txn(4'b0001, 5, 32'hDEADBEEF, w);

        randomize_fields();
        a_we[2]  = 1'b1;
        a_din[2] = 32'h55AA1234;
        a_be[2]  = 4'b0011;
        pack_fields();
        run_txn(4'b0100, 2, $urandom, w);

        randomize_fields();
        run_txn(4'b0010, 100, $urandom, w);
        randomize_fields();
        run_txn(4'b0010, 3, $urandom, w);

        randomize_fields();
        run_txn(4'b1000, TO - 1, 32'hCAFEF00D, w);

        // Reset while ISSUE is in progress, then a stray controller ack while idle.
        randomize_fields();
        i_req = 4'b1111;
        @(posedge clk); #1;
        check_value("pre_reset_p_req", o_p_req, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst        = 1'b0;
        model_last = NREQ - 1;
        i_req      = '0;
        i_p_ack    = 1'b1;
        i_p_dout   = $urandom;
        @(posedge clk); #1;
        check_value("stray_ack", o_ack, 0);
        check_value("stray_busy", o_busy, 0);
        check_value("stray_dout", o_dout, 0);
        i_p_ack = 1'b0;
        randomize_fields();
        run_txn(4'b1111, 0, $urandom, w);
        check_value("post_reset_winner", w, 0);

        for (int t = 0; t < 60; t++) begin
            randomize_fields();
            run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, TO + 2), $urandom, w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

endmodule
